// File: rtl/pipe_stage_skid.sv
// Parametrised inter-stage pipeline register with a valid/ready handshake and a 2-entry skid buffer.
// Flush inserts a bubble that keeps a PC/BD tag so exception logic can still form a correct EPC.
module pipe_stage_skid #(
   parameter int              DW      = 160,
   parameter int              PCW     = 32,
   parameter logic [PCW-1:0]  PC_RST  = '0,
   parameter bit              KEEP_PC = 1'b1
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           flush,
   input  logic [PCW-1:0] flush_pc,
   input  logic           flush_bd,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [DW-1:0]  in_data,
   input  logic [PCW-1:0] in_pc,
   input  logic           in_bd,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [DW-1:0]  out_data,
   output logic [PCW-1:0] out_pc,
   output logic           out_bd,
   output logic [1:0]     occupancy
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t         state;
   state_t         state_next;
   logic           in_ready_q;

   logic [DW-1:0]  main_data;
   logic [PCW-1:0] main_pc;
   logic           main_bd;
   logic [DW-1:0]  skid_data;
   logic [PCW-1:0] skid_pc;
   logic           skid_bd;

   logic           in_xfer;
   logic           out_xfer;
   logic           load_main_in;
   logic           load_main_skid;
   logic           load_skid;
   logic           clear_main;

   assign in_ready  = in_ready_q;
   assign out_valid = (state != EMPTY);
   assign out_data  = main_data;
   assign out_pc    = main_pc;
   assign out_bd    = main_bd;
   assign in_xfer   = in_valid & in_ready_q;
   assign out_xfer  = out_valid & out_ready;

   always_comb begin
      state_next     = state;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      clear_main     = 1'b0;
      case (state)
         EMPTY: begin
            if (in_xfer) begin
               load_main_in = 1'b1;
               state_next   = ONE;
            end
         end
         ONE: begin
            if (in_xfer && out_xfer) begin
               load_main_in = 1'b1;
            end else if (in_xfer) begin
               load_skid  = 1'b1;
               state_next = FULL;
            end else if (out_xfer) begin
               clear_main = 1'b1;
               state_next = EMPTY;
            end
         end
         FULL: begin
            if (out_xfer) begin
               load_main_skid = 1'b1;
               state_next     = ONE;
            end
         end
         default: state_next = EMPTY;
      endcase
   end

   // in_ready is registered from the next state so out_ready never reaches it combinationally
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         state      <= EMPTY;
         in_ready_q <= 1'b1;
      end else begin
         state      <= state_next;
         in_ready_q <= (state_next != FULL);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         main_data <= '0;
         main_pc   <= PC_RST;
         main_bd   <= 1'b0;
         skid_data <= '0;
         skid_pc   <= '0;
         skid_bd   <= 1'b0;
      end else if (flush) begin
         main_data <= '0;
         main_pc   <= KEEP_PC ? flush_pc : '0;
         main_bd   <= KEEP_PC ? flush_bd : 1'b0;
         skid_data <= '0;
         skid_pc   <= '0;
         skid_bd   <= 1'b0;
      end else begin
         // a drained bubble keeps its PC/BD tag; only the payload becomes a nop
         if (load_main_in) begin
            main_data <= in_data;
            main_pc   <= in_pc;
            main_bd   <= in_bd;
         end else if (load_main_skid) begin
            main_data <= skid_data;
            main_pc   <= skid_pc;
            main_bd   <= skid_bd;
         end else if (clear_main) begin
            main_data <= '0;
         end
         if (load_skid) begin
            skid_data <= in_data;
            skid_pc   <= in_pc;
            skid_bd   <= in_bd;
         end else if (load_main_skid) begin
            skid_data <= '0;
            skid_pc   <= '0;
            skid_bd   <= 1'b0;
         end
      end
   end

   always_comb begin
      occupancy = 2'd0;
      case (state)
         ONE:     occupancy = 2'd1;
         FULL:    occupancy = 2'd2;
         default: occupancy = 2'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         assert (state == EMPTY || state == ONE || state == FULL);
         assert (!(in_ready_q && state == FULL));
      end
   end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: directed handshake/flush/reset cases plus a long random run.
module tb_pipe_stage_skid;

   localparam int             DW     = 160;
   localparam int             PCW    = 32;
   localparam logic [PCW-1:0] PC_RST = 32'hBFC0_0000;

   typedef struct {
      logic [DW-1:0]  data;
      logic [PCW-1:0] pc;
      logic           bd;
   } item_t;

   logic           clk = 1'b0;
   logic           reset;
   logic           flush;
   logic [PCW-1:0] flush_pc;
   logic           flush_bd;
   logic           in_valid;
   logic           in_ready;
   logic [DW-1:0]  in_data;
   logic [PCW-1:0] in_pc;
   logic           in_bd;
   logic           out_valid;
   logic           out_ready;
   logic [DW-1:0]  out_data;
   logic [PCW-1:0] out_pc;
   logic           out_bd;
   logic [1:0]     occupancy;

   item_t          sb_q[$];
   int             check_count = 0;
   int             pass_count  = 0;

   pipe_stage_skid #(
      .DW(DW), .PCW(PCW), .PC_RST(PC_RST), .KEEP_PC(1'b1)
   ) dut (
      .clk(clk), .reset(reset), .flush(flush), .flush_pc(flush_pc), .flush_bd(flush_bd),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_pc(in_pc), .in_bd(in_bd),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_pc(out_pc),
      .out_bd(out_bd), .occupancy(occupancy)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      check_count++;
      if (obs !== exp)
         $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
      else
         pass_count++;
   endtask

   function automatic logic [DW-1:0] payload_for(input logic [PCW-1:0] pc);
      return {128'hAAAA_5555_0123_4567_89AB_CDEF_FEDC_BA98, pc};
   endfunction

   task automatic apply_stimulus(input logic iv, input logic [PCW-1:0] pc, input logic bd, input logic ordy);
      in_valid  = iv;
      in_pc     = pc;
      in_bd     = bd;
      in_data   = payload_for(pc);
      out_ready = ordy;
   endtask

   // Checks invariants and scoreboard before the edge, then advances to just after it
   task automatic cycle(input logic check_invariants);
      logic  in_fire;
      logic  out_fire;
      item_t it;
      in_fire  = in_valid && in_ready;
      out_fire = out_valid && out_ready;
      if (check_invariants) begin
         check_output("occupancy", DW'(occupancy), DW'(sb_q.size()));
         check_output("in_ready", DW'(in_ready), DW'(sb_q.size() != 2));
         check_output("out_valid", DW'(out_valid), DW'(sb_q.size() != 0));
         if (sb_q.size() == 0) check_output("bubble_data", out_data, '0);
      end
      if (reset || flush) begin
         sb_q.delete();
      end else begin
         if (out_fire) begin
            if (sb_q.size() == 0) begin
               check_output("sb_underflow", DW'(1), DW'(0));
            end else begin
               it = sb_q.pop_front();
               check_output("sb_data", out_data, it.data);
               check_output("sb_pc", DW'(out_pc), DW'(it.pc));
               check_output("sb_bd", DW'(out_bd), DW'(it.bd));
            end
         end
         if (in_fire) begin
            it.data = in_data;
            it.pc   = in_pc;
            it.bd   = in_bd;
            sb_q.push_back(it);
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [PCW-1:0] pc_seq;
      reset    = 1'b1;
      flush    = 1'b0;
      flush_pc = '0;
      flush_bd = 1'b0;
      apply_stimulus(1'b0, '0, 1'b0, 1'b0);
      repeat (2) cycle(1'b0);
      check_output("rst_valid", DW'(out_valid), DW'(0));
      check_output("rst_data", out_data, '0);
      check_output("rst_pc", DW'(out_pc), DW'(PC_RST));
      check_output("rst_occ", DW'(occupancy), DW'(0));
      check_output("rst_ready", DW'(in_ready), DW'(1));
      reset = 1'b0;

      // single transfer, 1-cycle latency, then drain to a bubble that keeps its tag
      apply_stimulus(1'b1, 32'h3000, 1'b0, 1'b1);
      cycle(1'b1);
      check_output("t1_valid", DW'(out_valid), DW'(1));
      check_output("t1_pc", DW'(out_pc), DW'(32'h3000));
      check_output("t1_occ", DW'(occupancy), DW'(1));
      apply_stimulus(1'b0, '0, 1'b0, 1'b1);
      cycle(1'b1);
      check_output("t1_drain_pc", DW'(out_pc), DW'(32'h3000));
      check_output("t1_drain_data", out_data, '0);

      // back-pressure fills the skid; third push waits; drain in order
      apply_stimulus(1'b1, 32'h3000, 1'b0, 1'b0);
      cycle(1'b1);
      apply_stimulus(1'b1, 32'h3004, 1'b1, 1'b0);
      cycle(1'b1);
      check_output("t2_occ", DW'(occupancy), DW'(2));
      check_output("t2_ready", DW'(in_ready), DW'(0));
      apply_stimulus(1'b1, 32'h3008, 1'b0, 1'b0);
      cycle(1'b1);
      check_output("t2_hold_pc", DW'(out_pc), DW'(32'h3000));
      apply_stimulus(1'b1, 32'h3008, 1'b0, 1'b1);
      repeat (2) cycle(1'b1);
      apply_stimulus(1'b0, '0, 1'b0, 1'b1);
      cycle(1'b1);
      check_output("t2_empty", DW'(sb_q.size()), DW'(0));

      // flush from FULL leaves a tagged bubble
      apply_stimulus(1'b1, 32'h300C, 1'b0, 1'b0);
      cycle(1'b1);
      apply_stimulus(1'b1, 32'h3010, 1'b0, 1'b0);
      cycle(1'b1);
      apply_stimulus(1'b0, '0, 1'b0, 1'b0);
      flush = 1'b1; flush_pc = 32'h3010; flush_bd = 1'b1;
      cycle(1'b1);
      flush = 1'b0;
      check_output("t3_valid", DW'(out_valid), DW'(0));
      check_output("t3_data", out_data, '0);
      check_output("t3_pc", DW'(out_pc), DW'(32'h3010));
      check_output("t3_bd", DW'(out_bd), DW'(1));
      check_output("t3_occ", DW'(occupancy), DW'(0));
      check_output("t3_ready", DW'(in_ready), DW'(1));

      // flush drops a same-cycle push; the following push flows normally
      apply_stimulus(1'b1, 32'h3020, 1'b0, 1'b0);
      flush = 1'b1; flush_pc = 32'h3014; flush_bd = 1'b0;
      cycle(1'b1);
      flush = 1'b0;
      check_output("t4_valid", DW'(out_valid), DW'(0));
      check_output("t4_pc", DW'(out_pc), DW'(32'h3014));
      apply_stimulus(1'b1, 32'h3024, 1'b0, 1'b1);
      cycle(1'b1);
      check_output("t4_next_pc", DW'(out_pc), DW'(32'h3024));
      apply_stimulus(1'b0, '0, 1'b0, 1'b1);
      cycle(1'b1);

      // reset beats flush when both hit a full stage
      apply_stimulus(1'b1, 32'h3028, 1'b1, 1'b0);
      cycle(1'b1);
      apply_stimulus(1'b1, 32'h302C, 1'b0, 1'b0);
      cycle(1'b1);
      check_output("t5_occ_full", DW'(occupancy), DW'(2));
      apply_stimulus(1'b0, '0, 1'b0, 1'b0);
      reset = 1'b1; flush = 1'b1; flush_pc = 32'h3030; flush_bd = 1'b1;
      cycle(1'b1);
      reset = 1'b0; flush = 1'b0;
      check_output("t5_pc", DW'(out_pc), DW'(PC_RST));
      check_output("t5_bd", DW'(out_bd), DW'(0));
      check_output("t5_occ", DW'(occupancy), DW'(0));
      check_output("t5_valid", DW'(out_valid), DW'(0));

      // random traffic against the scoreboard
      pc_seq = 32'h4000;
      for (int i = 0; i < 10000; i++) begin
         apply_stimulus(1'($urandom_range(0, 1)), pc_seq, 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)));
         in_data = {$urandom, $urandom, $urandom, $urandom, $urandom};
         if (in_valid && in_ready) pc_seq = pc_seq + 32'd4;
         cycle(1'b1);
      end
      apply_stimulus(1'b0, '0, 1'b0, 1'b1);
      repeat (3) cycle(1'b1);
      check_output("final_empty", DW'(sb_q.size()), DW'(0));

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
